// File: rtl/pipe_dff_if.sv
// pipe_dff_if: stage enable plus array-shaped data into and out of a pipe_dff.
interface pipe_dff_if #(
  parameter int WIDTH       = 1,
  parameter int ARRAY_SIZE1 = 1,
  parameter int ARRAY_SIZE2 = 1
);
  logic             en;
  logic [WIDTH-1:0] in  [ARRAY_SIZE1][ARRAY_SIZE2];
  logic [WIDTH-1:0] out [ARRAY_SIZE1][ARRAY_SIZE2];
  modport master (output en, output in, input out);
  modport slave (input en, input in, output out);
endinterface

// File: rtl/pipe_dff.sv
// pipe_dff: fixed-depth register pipeline for scalars, 1-D and 2-D word arrays.
// Define PIPE_DFF_CHECK_EN to compile parameter and X-control checks.
module pipe_dff #(
  parameter int WIDTH         = 1,
  parameter int ARRAY_SIZE1   = 1,
  parameter int ARRAY_SIZE2   = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter bit RETIME_STATUS = 0
) (
  input logic       clk,
  input logic       reset,
  pipe_dff_if.slave bus
);
  if (PIPE_DEPTH == 0) begin : g_wire
    assign bus.out = bus.in;
  end else if (RETIME_STATUS) begin : g_retime
    (* retiming_backward = 1, retiming_forward = 1 *)
    logic [WIDTH-1:0] stage [PIPE_DEPTH][ARRAY_SIZE1][ARRAY_SIZE2];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < PIPE_DEPTH; k++)
          for (int i = 0; i < ARRAY_SIZE1; i++)
            for (int j = 0; j < ARRAY_SIZE2; j++)
              stage[k][i][j] <= '0;
      end else if (bus.en) begin
        stage[0] <= bus.in;
        for (int k = 1; k < PIPE_DEPTH; k++)
          stage[k] <= stage[k-1];
      end
    end
    assign bus.out = stage[PIPE_DEPTH-1];
  end else begin : g_fixed
    (* dont_retime = 1 *)
    logic [WIDTH-1:0] stage [PIPE_DEPTH][ARRAY_SIZE1][ARRAY_SIZE2];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < PIPE_DEPTH; k++)
          for (int i = 0; i < ARRAY_SIZE1; i++)
            for (int j = 0; j < ARRAY_SIZE2; j++)
              stage[k][i][j] <= '0;
      end else if (bus.en) begin
        stage[0] <= bus.in;
        for (int k = 1; k < PIPE_DEPTH; k++)
          stage[k] <= stage[k-1];
      end
    end
    assign bus.out = stage[PIPE_DEPTH-1];
  end
`ifdef PIPE_DFF_CHECK_EN
  if (WIDTH < 1 || ARRAY_SIZE1 < 1 || ARRAY_SIZE2 < 1 || PIPE_DEPTH < 0) begin : g_bad_params
    $error("pipe_dff: illegal parameter combination");
  end
  a_ctrl_known: assert property (@(posedge clk) !$isunknown({reset, bus.en}))
    else $error("pipe_dff: reset or en unknown at clock edge");
`else
`endif
endmodule

// File: tb/tb_pipe_dff.sv
// tb_pipe_dff: directed checks of pipe_dff across scalar, 1-D, 2-D and zero-depth shapes.
module tb_pipe_dff;
  logic clk = 0;
  logic reset;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_dff_if #(.WIDTH(32)) if_a ();
  pipe_dff_if #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3)) if_b ();
  pipe_dff_if #(.WIDTH(8)) if_c3 ();
  pipe_dff_if #(.WIDTH(8)) if_c2 ();
  pipe_dff_if #(.WIDTH(8)) if_d ();
  pipe_dff_if #(.WIDTH(8), .ARRAY_SIZE1(3)) if_z ();

  pipe_dff #(.WIDTH(32), .PIPE_DEPTH(1)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  pipe_dff #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  pipe_dff #(.WIDTH(8), .PIPE_DEPTH(3), .RETIME_STATUS(1)) u_c3 (.clk(clk), .reset(reset), .bus(if_c3));
  pipe_dff #(.WIDTH(8), .PIPE_DEPTH(2)) u_c2 (.clk(clk), .reset(reset), .bus(if_c2));
  pipe_dff #(.WIDTH(8), .PIPE_DEPTH(2)) u_d (.clk(clk), .reset(reset), .bus(if_d));
  pipe_dff #(.WIDTH(8), .ARRAY_SIZE1(3), .PIPE_DEPTH(0)) u_z (.clk(clk), .reset(reset), .bus(if_z));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic [7:0] v);
    if_c3.in[0][0] = v;
    if_c2.in[0][0] = v;
  endtask

  initial begin
    reset = 1;
    if_a.en = 1; if_a.in[0][0] = 32'h0;
    if_b.en = 1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_b.in[i][j] = 24'h0;
    if_c3.en = 1; if_c2.en = 1; set_c(8'h0);
    if_d.en = 1; if_d.in[0][0] = 8'h0;
    if_z.en = 0;
    for (int i = 0; i < 3; i++) if_z.in[i][0] = 8'h0;
    tick();
    tick();
    check("reset_a", if_a.out[0][0], 32'h0);
    check("reset_b", if_b.out[2][2], 32'h0);
    check("reset_c3", if_c3.out[0][0], 32'h0);
    check("reset_d", if_d.out[0][0], 32'h0);
    reset = 0;

    if_a.in[0][0] = 32'd5; tick(); check("scalar_5", if_a.out[0][0], 32'd5);
    if_a.in[0][0] = 32'd6; tick(); check("scalar_6", if_a.out[0][0], 32'd6);
    if_a.in[0][0] = 32'd7; tick(); check("scalar_7", if_a.out[0][0], 32'd7);
    if_a.in[0][0] = 32'hABCDEF; tick(); check("scalar_abcdef", if_a.out[0][0], 32'hABCDEF);
    reset = 1; tick(); check("scalar_reset_en", if_a.out[0][0], 32'h0);
    reset = 0; tick(); check("scalar_after_reset", if_a.out[0][0], 32'hABCDEF);

    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_b.in[i][j] = 24'(16 * i + j);
    tick();
    check("arr_edge1", if_b.out[1][2], 32'h0);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if_b.in[i][j] = 24'hFFFFFF;
    tick();
    check("arr_edge2", if_b.out[2][1], 32'h0);
    tick();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check($sformatf("arr_edge3_%0d_%0d", i, j), if_b.out[i][j], 32'(16 * i + j));
    tick();
    check("arr_edge4", if_b.out[0][1], 32'hFFFFFF);

    set_c(8'h5A);
    tick();
    check("d2_edge1", if_c2.out[0][0], 32'h0);
    check("d3_edge1", if_c3.out[0][0], 32'h0);
    tick();
    check("d2_edge2", if_c2.out[0][0], 32'h5A);
    check("d3_edge2", if_c3.out[0][0], 32'h0);
    tick();
    check("d2_edge3", if_c2.out[0][0], 32'h5A);
    check("d3_edge3", if_c3.out[0][0], 32'h5A);

    if_d.in[0][0] = 8'h01; tick();
    if_d.in[0][0] = 8'h02; tick();
    check("en_prime", if_d.out[0][0], 32'h01);
    if_d.en = 0; if_d.in[0][0] = 8'h03; tick();
    check("en_hold1", if_d.out[0][0], 32'h01);
    if_d.in[0][0] = 8'h04; tick();
    check("en_hold2", if_d.out[0][0], 32'h01);
    if_d.en = 1; if_d.in[0][0] = 8'h09; tick();
    check("en_resume1", if_d.out[0][0], 32'h02);
    tick();
    check("en_resume2", if_d.out[0][0], 32'h09);

    if_d.in[0][0] = 8'h11; tick(); tick();
    check("mid_pre", if_d.out[0][0], 32'h11);
    reset = 1; tick();
    check("mid_reset", if_d.out[0][0], 32'h0);
    reset = 0; if_d.in[0][0] = 8'h22; tick();
    check("mid_post1", if_d.out[0][0], 32'h0);
    tick();
    check("mid_post2", if_d.out[0][0], 32'h22);

    for (int i = 0; i < 3; i++) if_z.in[i][0] = 8'(i + 1);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("d0_track_%0d", i), if_z.out[i][0], 32'(i + 1));
    reset = 1; tick();
    check("d0_reset", if_z.out[1][0], 32'h2);
    if_z.in[1][0] = 8'hC3; #1;
    check("d0_change", if_z.out[1][0], 32'hC3);
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_dff.md
# pipe_dff

Parameterized register pipeline used throughout the rasterizer datapath and scoreboards to delay scalars, 1-D arrays and 2-D arrays of words by a fixed number of clock cycles. One module serves all three shapes: a scalar is a 1×1 array, a 1-D array is N×1. Typical uses are staging triangle vertices, colours, sample positions, valid bits and counters to align them with later pipeline stages.

## Interface
- WIDTH, 1: bits per element.
- ARRAY_SIZE1, 1: outer array dimension, ≥1.
- ARRAY_SIZE2, 1: inner array dimension, ≥1.
- PIPE_DEPTH, 1: number of register stages, ≥0.
- RETIME_STATUS, 0: 0 = fixed stage placement; 1 = stages marked retimeable by synthesis. Function is identical.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  stage enable; 1 = advance, 0 = hold.
- in  input  [ARRAY_SIZE1][ARRAY_SIZE2] × WIDTH  data into stage 0 (unpacked array of WIDTH-bit logic vectors).
- out  output  [ARRAY_SIZE1][ARRAY_SIZE2] × WIDTH  data from the last stage; same shape as in.

## Operation
- Internal state: PIPE_DEPTH stages, each a full ARRAY_SIZE1×ARRAY_SIZE2×WIDTH array.
- PIPE_DEPTH = 0: out = in combinationally. No state; clk, reset and en are ignored.
- PIPE_DEPTH ≥ 1, at each rising clk:
  - reset = 1: every element of every stage becomes 0.
  - reset = 0, en = 1: stage 0 takes in; stage k takes stage k-1.
  - reset = 0, en = 0: all stages hold their values.
- out = last stage. It is a direct register output with no combinational path from in.
- Data is opaque. There is no sign handling; signed and unsigned callers get bit-exact copies.
- Elements are independent. Element [i][j] of in appears only at [i][j] of out.
- RETIME_STATUS = 1: the implementation may emit the same stage count in a form synthesis can move, such as a pipelined chain with retiming attributes. Cycle behaviour matches RETIME_STATUS = 0 exactly.

## Timing
- Latency with en held high: out(t) = in(t − PIPE_DEPTH) cycles.
- With en toggling: a value reaches out after PIPE_DEPTH enabled edges. Disabled edges do not count.
- Reset value of out: all zeros, visible one edge after reset is sampled high. Before the first reset, out is X.
- Reset and en both high: reset wins and the stages clear.
- Reset mid-stream: all in-flight data is discarded in one edge. After reset deasserts, out shows 0 for PIPE_DEPTH enabled edges, then the first post-reset input.
- Two instances fed the same in with depths D and D−1 differ by exactly one enabled cycle. Callers rely on this for new-item detection.

## Configuration
- PIPE_DFF_CHECK_EN defined:
  - elaboration fails if WIDTH < 1, ARRAY_SIZE1 < 1, ARRAY_SIZE2 < 1 or PIPE_DEPTH < 0;
  - a clocked assertion reports an error when reset or en is X/Z at a rising clk.
- PIPE_DFF_CHECK_EN undefined: no checks are compiled. Functional behaviour is identical.

## Test plan
- Scalar, WIDTH=32, PIPE_DEPTH=1, en=1: drive in = 5, 6, 7 on successive cycles → out = 5, 6, 7 one cycle later. With reset high, out = 0 on the next edge.
- 2-D array, WIDTH=24, 3×3, PIPE_DEPTH=3: element [i][j] = 16·i + j → the identical array appears exactly 3 edges later; no element crosses positions.
- Depth 3 vs depth 2 on the same input stream: a change at in shows at the depth-2 output one edge before the depth-3 output, and the two outputs differ for exactly one cycle.
- PIPE_DEPTH=2, en low for 2 cycles mid-stream: out freezes. After en rises, the held value advances and no input sampled while en was low appears at out.
- Reset asserted with en=1 while pipeline holds 0xABCDEF: out = 0 the next edge. Reset and en high together still clear.
- PIPE_DEPTH=0, 1-D array of 3: out tracks in in the same cycle; reset has no effect.
